frame_write_ctrl: RTL and testbench



---
 rtl/frame_write_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_frame_write_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_write_ctrl.sv
// ---------------------------------------------------------------------------
// frame_write_ctrl
//
// Accepts the line generator's pixel stream, converts each in-range pixel to
// a linear address, buffers {addr, colour} in a small FIFO and writes it into
// the back half of a double-buffered frame memory over a req/ack port.
// On raster_done the block stops accepting pixels, drains every pending
// write, then swaps front/back buffers on the next vsync.
//
// Optional feature: define FWC_DROP_CNT_EN to count out-of-range pixels on
// pixel_drop_cnt (saturating). Without it pixel_drop_cnt is tied to zero.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   frame_rd_en         pixel valid from the line generator
//   frame_x, frame_y    pixel column / row
//   px_color            pixel colour
//   raster_done         one-cycle pulse: the whole frame has been issued
//   frame_ready         pixel accept (registered-state only)
//   vsync               one-cycle pulse at start of vertical blank
//   mem_we              write request, held until mem_ack
//   mem_addr            {buffer select, linear address}
//   mem_wdata           write colour
//   mem_ack             write accepted
//   disp_buf            buffer currently shown by the display
//   swap_pending        raster_done seen, swap not yet performed
//   pixel_drop_cnt      out-of-range pixel count (optional)
// ---------------------------------------------------------------------------
module frame_write_ctrl #(
    parameter int DEPTH  = 8,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_rd_en,
    input  logic [9:0]        frame_x,
    input  logic [8:0]        frame_y,
    input  logic [2:0]        px_color,
    input  logic              raster_done,
    output logic              frame_ready,
    input  logic              vsync,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [2:0]        mem_wdata,
    input  logic              mem_ack,
    output logic              disp_buf,
    output logic              swap_pending,
    output logic [15:0]       pixel_drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        colour;
    } entry_t;

    typedef enum logic       {W_IDLE, W_REQ}                w_state_e;
    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_WAIT_VS}    s_state_e;

    entry_t            fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    w_state_e          w_state_q;
    s_state_e          s_state_q;
    logic              ready_en_q;
    logic              mem_we_q;
    logic [ADDR_W:0]   mem_addr_q;
    logic [2:0]        mem_wdata_q;
    logic              disp_buf_q;
    logic              swap_pending_q;

    logic              accept, in_range, push_req, fifo_empty;
    logic              load, bypass, do_push, do_pop;
    entry_t            push_entry, head_entry;

    // ready_en_q keeps frame_ready low while in reset and lets it rise on
    // the first clock afterwards.
    assign frame_ready = ready_en_q & (count_q < CNT_W'(DEPTH)) & ~swap_pending_q;
    assign accept      = frame_rd_en & frame_ready;
    assign in_range    = (32'(frame_x) < H_RES) && (32'(frame_y) < V_RES);
    assign push_req    = accept & in_range;
    assign fifo_empty  = (count_q == '0);

    assign push_entry.addr   = ADDR_W'(frame_y) * ADDR_W'(H_RES) + ADDR_W'(frame_x);
    assign push_entry.colour = px_color;

    // With an empty FIFO the incoming pixel goes straight to the output
    // registers, giving one-cycle accept-to-request latency and one write
    // per cycle under continuous ack.
    assign head_entry = fifo_empty ? push_entry : fifo_mem[rd_ptr_q];
    assign load    = (!fifo_empty || push_req) &&
                     ((w_state_q == W_IDLE) || mem_ack);
    assign bypass  = load && fifo_empty;
    assign do_push = push_req && !bypass;
    assign do_pop  = load && !fifo_empty;

    // NOTE: every variable of an always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)
            count_d = count_q + CNT_W'(1);
        else if (!do_push && do_pop)
            count_d = count_q - CNT_W'(1);
    end

    // NOTE: the storage array has no reset; the pointers and count alone
    // decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push)
            fifo_mem[wr_ptr_q] <= push_entry;
    end

    // NOTE: clocked blocks use non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            count_q    <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Write FSM. The buffer-select bit is captured with the entry, so a
    // later swap never retargets a write already on the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q   <= W_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (load) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {~disp_buf_q, head_entry.addr};
                        mem_wdata_q <= head_entry.colour;
                        w_state_q   <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (mem_ack) begin
                        if (load) begin
                            mem_addr_q  <= {~disp_buf_q, head_entry.addr};
                            mem_wdata_q <= head_entry.colour;
                        end else begin
                            mem_we_q  <= 1'b0;
                            w_state_q <= W_IDLE;
                        end
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Swap FSM. A vsync seen during the drain, or in the very cycle the
    // drain completes, is ignored; only S_WAIT_VS reacts to vsync.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_state_q      <= S_RUN;
            swap_pending_q <= 1'b0;
            disp_buf_q     <= 1'b0;
        end else begin
            case (s_state_q)
                S_RUN: begin
                    if (raster_done) begin
                        swap_pending_q <= 1'b1;
                        s_state_q      <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty && (w_state_q == W_IDLE))
                        s_state_q <= S_WAIT_VS;
                end
                S_WAIT_VS: begin
                    if (vsync) begin
                        disp_buf_q     <= ~disp_buf_q;
                        swap_pending_q <= 1'b0;
                        s_state_q      <= S_RUN;
                    end
                end
                default: s_state_q <= S_RUN;
            endcase
        end
    end

`ifdef FWC_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt_q <= '0;
        else if (accept && !in_range && (drop_cnt_q != 16'hFFFF))
            drop_cnt_q <= drop_cnt_q + 16'd1;
    end

    assign pixel_drop_cnt = drop_cnt_q;
`else
    assign pixel_drop_cnt = '0;
`endif

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign disp_buf     = disp_buf_q;
    assign swap_pending = swap_pending_q;

endmodule

// File: tb/tb_frame_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frame_write_ctrl
//
// Directed bench for frame_write_ctrl. Expected writes are pushed to a
// scoreboard queue as pixels are accepted and popped by a monitor on every
// completed mem_we/mem_ack handshake. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_frame_write_ctrl;

    typedef struct packed {
        logic [19:0] addr;
        logic [2:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_rd_en, raster_done, vsync, mem_ack;
    logic [9:0]  frame_x;
    logic [8:0]  frame_y;
    logic [2:0]  px_color;
    logic        frame_ready, mem_we, disp_buf, swap_pending;
    logic [19:0] mem_addr;
    logic [2:0]  mem_wdata;
    logic [15:0] pixel_drop_cnt;

    wr_t  sb[$];
    wr_t  mon_e;
    int   tests    = 0;
    int   fails    = 0;
    int   n_writes = 0;
    logic exp_disp = 1'b0;

    frame_write_ctrl #(.DEPTH(8), .H_RES(640), .V_RES(480), .ADDR_W(19)) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_rd_en    (frame_rd_en),
        .frame_x        (frame_x),
        .frame_y        (frame_y),
        .px_color       (px_color),
        .raster_done    (raster_done),
        .frame_ready    (frame_ready),
        .vsync          (vsync),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .disp_buf       (disp_buf),
        .swap_pending   (swap_pending),
        .pixel_drop_cnt (pixel_drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, required finish before 2 ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic wr_t exp_entry(input logic [9:0] x, input logic [8:0] y,
                                      input logic [2:0] c);
        wr_t e;
        e.addr = {~exp_disp, 19'(int'(y) * 640 + int'(x))};
        e.data = c;
        return e;
    endfunction

    // Scoreboard monitor: every completed handshake must match the oldest
    // expected write.
    always @(negedge clk) begin
        if (rst === 1'b0 && mem_we === 1'b1 && mem_ack === 1'b1) begin
            n_writes++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL wr_unexpected: observed write to 0x%0h, required no write", mem_addr);
            end else begin
                mon_e = sb.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                check("wr_data", 32'(mem_wdata), 32'(mon_e.data));
            end
        end
    end

    // Offers one pixel and holds it until accepted (bounded).
    task automatic send_pixel(input logic [9:0] x, input logic [8:0] y,
                              input logic [2:0] c, output int waited);
        frame_x = x; frame_y = y; px_color = c; frame_rd_en = 1'b1;
        waited = 0;
        @(negedge clk);
        while (frame_ready !== 1'b1 && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (frame_ready !== 1'b1) begin
            tests++;
            fails++;
            $error("FAIL accept_timeout: observed frame_ready=%b, required 1 within 50 cycles", frame_ready);
        end else if (x < 10'd640 && y < 9'd480) begin
            sb.push_back(exp_entry(x, y, c));
        end
        @(posedge clk); #1;
        frame_rd_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((sb.size() != 0 || mem_we !== 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int w, wsum, bad, n0;
        rst = 1'b1; frame_rd_en = 1'b0; raster_done = 1'b0; vsync = 1'b0;
        mem_ack = 1'b0; frame_x = '0; frame_y = '0; px_color = '0;

        // ---- reset values ------------------------------------------------
        @(negedge clk);
        check("rst_frame_ready", 32'(frame_ready), 32'd0);
        check("rst_mem_we",      32'(mem_we),      32'd0);
        check("rst_mem_addr",    32'(mem_addr),    32'd0);
        check("rst_mem_wdata",   32'(mem_wdata),   32'd0);
        check("rst_disp_buf",    32'(disp_buf),    32'd0);
        check("rst_swap_pend",   32'(swap_pending), 32'd0);
        check("rst_drop_cnt",    32'(pixel_drop_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_before_clk", 32'(frame_ready), 32'd0);
        @(negedge clk);
        check("ready_after_clk", 32'(frame_ready), 32'd1);
        @(posedge clk); #1;

        // ---- single pixel, ack in the same cycle --------------------------
        mem_ack = 1'b1;
        send_pixel(10'd5, 9'd2, 3'b101, w);
        check("t1_wait", 32'(w), 32'd0);
        @(negedge clk);
        check("t1_mem_we",    32'(mem_we),    32'd1);
        check("t1_mem_addr",  32'(mem_addr),  32'h80505);
        check("t1_mem_wdata", 32'(mem_wdata), 32'd5);
        @(negedge clk);
        check("t1_we_drop",   32'(mem_we),    32'd0);
        @(posedge clk); #1;

        // ---- backpressure: 8 in FIFO + 1 in flight ------------------------
        mem_ack = 1'b0;
        wsum = 0;
        for (int i = 0; i < 9; i++) begin
            send_pixel(10'(20 + i), 9'd3, 3'(i), w);
            wsum += w;
        end
        check("t2_nine_accepted", 32'(wsum), 32'd0);
        frame_x = 10'd100; frame_y = 9'd7; px_color = 3'd6; frame_rd_en = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (frame_ready !== 1'b0 || mem_we !== 1'b1) bad++;
        end
        check("t2_full_stall", 32'(bad), 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b1;
        @(negedge clk);
        check("t2_full_with_pop", 32'(frame_ready), 32'd0);
        @(negedge clk);
        check("t2_ready_return", 32'(frame_ready), 32'd1);
        sb.push_back(exp_entry(10'd100, 9'd7, 3'd6));
        @(posedge clk); #1;
        frame_rd_en = 1'b0;
        wait_idle("t2_drain");
        check("t2_write_count", 32'(n_writes), 32'd11);

        // ---- range boundary and out-of-range pixels -----------------------
        send_pixel(10'd639, 9'd479, 3'd2, w);
        wait_idle("t3_corner");
        n0 = n_writes;
        send_pixel(10'd640, 9'd0, 3'd1, w);
        send_pixel(10'd0, 9'd480, 3'd1, w);
        cycles(5);
        check("t3_no_writes", 32'(n_writes), 32'(n0));
`ifdef FWC_DROP_CNT_EN
        check("t3_drop_cnt", 32'(pixel_drop_cnt), 32'd2);
`else
        check("t3_drop_cnt", 32'(pixel_drop_cnt), 32'd0);
`endif

        // ---- raster_done with 3 queued, vsync mid-drain -------------------
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) send_pixel(10'(i), 9'd10, 3'(i + 1), w);
        raster_done = 1'b1;
        @(posedge clk); #1;
        raster_done = 1'b0;
        @(negedge clk);
        check("t4_swap_pending", 32'(swap_pending), 32'd1);
        check("t4_ready_low",    32'(frame_ready),  32'd0);
        @(posedge clk); #1;
        vsync = 1'b1;
        @(posedge clk); #1;
        vsync = 1'b0;
        mem_ack = 1'b1;
        bad = 0;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            if (frame_ready !== 1'b0 || disp_buf !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        check("t4_hold_until_vsync", 32'(bad), 32'd0);
        check("t4_drained", 32'(sb.size()), 32'd0);
        vsync = 1'b1;
        @(posedge clk); #1;
        vsync = 1'b0;
        exp_disp = 1'b1;
        @(negedge clk);
        check("t4_disp_buf", 32'(disp_buf),     32'd1);
        check("t4_pend_clr", 32'(swap_pending), 32'd0);
        check("t4_ready",    32'(frame_ready),  32'd1);
        @(posedge clk); #1;
        send_pixel(10'd1, 9'd0, 3'd3, w);
        @(negedge clk);
        check("t4_msb_back0", 32'(mem_addr), 32'h00001);
        wait_idle("t4_post");

        // ---- drain completion coincident with vsync -----------------------
        mem_ack = 1'b0;
        send_pixel(10'd7, 9'd1, 3'd4, w);
        raster_done = 1'b1;
        @(posedge clk); #1;
        raster_done = 1'b0;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        vsync = 1'b1;
        @(posedge clk); #1;
        vsync = 1'b0;
        @(negedge clk);
        check("t5_no_toggle",   32'(disp_buf),     32'd1);
        check("t5_still_pend",  32'(swap_pending), 32'd1);
        @(posedge clk); #1;
        cycles(3);
        vsync = 1'b1;
        @(posedge clk); #1;
        vsync = 1'b0;
        exp_disp = 1'b0;
        @(negedge clk);
        check("t5_toggle", 32'(disp_buf),     32'd0);
        check("t5_clear",  32'(swap_pending), 32'd0);
        check("t5_writes_done", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;

        // ---- reset during W_REQ with 4 queued -----------------------------
        for (int i = 0; i < 5; i++) send_pixel(10'(50 + i), 9'd20, 3'(i), w);
        #2;
        rst = 1'b1;
        #1;
        check("t6_we_async",    32'(mem_we),       32'd0);
        check("t6_addr",        32'(mem_addr),     32'd0);
        check("t6_wdata",       32'(mem_wdata),    32'd0);
        check("t6_ready",       32'(frame_ready),  32'd0);
        check("t6_disp",        32'(disp_buf),     32'd0);
        check("t6_pend",        32'(swap_pending), 32'd0);
        check("t6_drop",        32'(pixel_drop_cnt), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b1;
        n0 = n_writes;
        @(negedge clk);
        check("t6_ready_wait", 32'(frame_ready), 32'd0);
        @(negedge clk);
        check("t6_ready_up",   32'(frame_ready), 32'd1);
        cycles(5);
        check("t6_fifo_empty", 32'(n_writes), 32'(n0));
        check("t6_we_idle",    32'(mem_we),   32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
